subblock_reader: RTL and testbench
==================================

SUBBLOCK_READER -- requirements
Module: subblock_reader

Interface
REQ-001 Parameter: BYTES_SHORT, default 132, number of bytes per subblock when length_out=0 (1056-bit code block).
REQ-002 Parameter: BYTES_LONG, default 768, number of bytes per subblock when length_out=1 (6144-bit code block).
REQ-003 Ports:
- clk  input  1  sole clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-high.
- computation_done  input  1  encoder has finished; the three subblock FIFOs hold a complete block.
- length_out  input  1  code block length of the finished block; 0 = short, 1 = long.
- q0, q1, q2  input  8 each  subblock FIFO read data.
- rdreq_subblock  output  1  single read strobe shared by all three subblock FIFOs.
- out_data  output  8  serialized output byte.
- out_valid  output  1  out_data is valid.
- out_ready  input  1  downstream accepts out_data.
- frame_start  output  1  high with the first byte of a frame.
- frame_end  output  1  high with the last byte of a frame.
- busy  output  1  a frame is in progress.
- frame_done  output  1  one-cycle pulse after the last byte is accepted.

Function
REQ-004 States SHALL be IDLE, REQ, CAPT, E0, E1, E2, PAR0, PAR1, PAR2 and DONE.
REQ-005 IDLE: when computation_done=1, the block SHALL latch length_out, load the byte counter with BYTES_SHORT or BYTES_LONG, clear the parity registers, set busy, and go to REQ.
REQ-006 REQ: rdreq_subblock SHALL be 1 for exactly this one cycle; the next state is CAPT.
REQ-007 CAPT: the block SHALL register q0, q1 and q2 into holding registers (FIFO read latency is 1 cycle), XOR each into its parity register, and go to E0.
REQ-008 E0, E1 and E2 SHALL drive the held q0, q1 and q2 byte respectively, with out_valid=1.
REQ-009 A state SHALL advance only on a cycle where out_valid and out_ready are both 1; out_data SHALL remain stable while out_ready=0.
REQ-010 E2 accepted: the counter SHALL decrement; when it reaches 0 the next state is PAR0 if the parity feature is compiled in, otherwise DONE; if it does not reach 0 the next state is REQ.
REQ-011 Consequently exactly one rdreq_subblock SHALL be issued per byte triple, and never while the FIFOs hold no unread data for the current frame.
REQ-012 frame_start SHALL be 1 only in the first E0 of a frame.
REQ-013 frame_end SHALL be 1 in the last emitted state of a frame: the final E2, or PAR2 when parity is enabled.
REQ-014 DONE: frame_done SHALL pulse for one cycle, busy SHALL clear, and the next state is IDLE.
REQ-015 The block SHALL sample computation_done only in IDLE; assertions while busy SHALL be ignored.
REQ-016 If computation_done is still high on the cycle after DONE, a new frame SHALL start.
REQ-017 The byte counter SHALL be 10 bits wide and SHALL never wrap: it is decremented only while nonzero.
REQ-018 A frame SHALL carry 3*BYTES_SHORT or 3*BYTES_LONG data bytes, plus 3 bytes when parity is enabled.

Reset
REQ-019 While reset=1 the block SHALL be in IDLE with all outputs 0.
REQ-020 While reset=1 all of the following SHALL be 0: out_data, the holding registers, the parity registers, the counter and the latched length.
REQ-021 Reset asserted mid-frame SHALL abort the frame immediately with no frame_done; after release the block SHALL wait in IDLE for computation_done.

Configuration
REQ-022 Macro SUBBLOCK_PARITY_EN defined: after the last E2, states PAR0, PAR1 and PAR2 SHALL emit the XOR of all q0, q1 and q2 bytes of the frame, under the same handshake as E0-E2.
REQ-023 Macro SUBBLOCK_PARITY_EN undefined: the parity states and registers SHALL not exist, and the frame SHALL end at the last E2.

Verification
REQ-024 Short frame: length_out=0, computation_done pulse, out_ready=1 -> 132 rdreq pulses; 396 bytes in order q0,q1,q2 per triple; frame_start on byte 0; frame_end on byte 395; one frame_done.
REQ-025 Long frame: length_out=1 -> 768 rdreq pulses and 2304 bytes; counter ends at 0 with no wrap.
REQ-026 Backpressure: out_ready toggling 0/1 every cycle -> out_data stable while out_ready=0; no byte lost or duplicated; rdreq never issued outside REQ.
REQ-027 Parity (SUBBLOCK_PARITY_EN): all q0=8'hA5, q1=8'h3C, q2=8'hFF, short frame -> 132 is even so trailer is 00,00,00; with one q0 byte changed to 8'h5A -> trailer is FF,00,00.
REQ-028 Reset mid-frame at byte 50 -> outputs 0 asynchronously; no frame_done; a new computation_done starts a fresh frame with frame_start.
REQ-029 computation_done held high through a frame -> it is ignored while busy, and a second frame starts the cycle after DONE.

Source files
------------

// File: rtl/subblock_reader.sv
// Drains three subblock FIFOs in lock-step and serialises each q0,q1,q2 triple onto a
// valid/ready byte stream. Define SUBBLOCK_PARITY_EN to append a 3-byte XOR trailer per frame.
module subblock_reader #(
    parameter int unsigned BYTES_SHORT = 132,
    parameter int unsigned BYTES_LONG  = 768
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       computation_done,
    input  logic       length_out,
    input  logic [7:0] q0,
    input  logic [7:0] q1,
    input  logic [7:0] q2,
    output logic       rdreq_subblock,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       frame_start,
    output logic       frame_end,
    output logic       busy,
    output logic       frame_done
);

    localparam logic [9:0] CntShort = 10'(BYTES_SHORT);
    localparam logic [9:0] CntLong  = 10'(BYTES_LONG);

    typedef enum logic [3:0] {
        StIdle, StReq, StCapt, StE0, StE1, StE2,
`ifdef SUBBLOCK_PARITY_EN
        StPar0, StPar1, StPar2,
`endif
        StDone
    } state_e;

    state_e     state_q, state_d;
    logic [9:0] cnt_q, cnt_d;
    logic       len_q, len_d;
    logic [7:0] h0_q, h0_d, h1_q, h1_d, h2_q, h2_d;
`ifdef SUBBLOCK_PARITY_EN
    logic [7:0] p0_q, p0_d, p1_q, p1_d, p2_q, p2_d;
`endif

    // The triple now in E0..E2 is the last one of the frame.
    logic last_triple;
    assign last_triple = (cnt_q <= 10'd1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            len_q   <= 1'b0;
            h0_q    <= '0;
            h1_q    <= '0;
            h2_q    <= '0;
`ifdef SUBBLOCK_PARITY_EN
            p0_q    <= '0;
            p1_q    <= '0;
            p2_q    <= '0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            h0_q    <= h0_d;
            h1_q    <= h1_d;
            h2_q    <= h2_d;
`ifdef SUBBLOCK_PARITY_EN
            p0_q    <= p0_d;
            p1_q    <= p1_d;
            p2_q    <= p2_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        h0_d    = h0_q;
        h1_d    = h1_q;
        h2_d    = h2_q;
`ifdef SUBBLOCK_PARITY_EN
        p0_d    = p0_q;
        p1_d    = p1_q;
        p2_d    = p2_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (computation_done) begin
                    len_d   = length_out;
                    cnt_d   = length_out ? CntLong : CntShort;
`ifdef SUBBLOCK_PARITY_EN
                    p0_d    = '0;
                    p1_d    = '0;
                    p2_d    = '0;
`endif
                    state_d = StReq;
                end
            end
            StReq: state_d = StCapt;
            StCapt: begin
                // FIFO data appears one cycle after the read strobe.
                h0_d    = q0;
                h1_d    = q1;
                h2_d    = q2;
`ifdef SUBBLOCK_PARITY_EN
                p0_d    = p0_q ^ q0;
                p1_d    = p1_q ^ q1;
                p2_d    = p2_q ^ q2;
`endif
                state_d = StE0;
            end
            StE0: if (out_ready) state_d = StE1;
            StE1: if (out_ready) state_d = StE2;
            StE2: begin
                if (out_ready) begin
                    if (cnt_q != 10'd0) cnt_d = cnt_q - 10'd1;
`ifdef SUBBLOCK_PARITY_EN
                    state_d = last_triple ? StPar0 : StReq;
`else
                    state_d = last_triple ? StDone : StReq;
`endif
                end
            end
`ifdef SUBBLOCK_PARITY_EN
            StPar0: if (out_ready) state_d = StPar1;
            StPar1: if (out_ready) state_d = StPar2;
            StPar2: if (out_ready) state_d = StDone;
`endif
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        rdreq_subblock = 1'b0;
        out_data       = '0;
        out_valid      = 1'b0;
        frame_start    = 1'b0;
        frame_end      = 1'b0;
        frame_done     = 1'b0;
        busy           = (state_q != StIdle) && (state_q != StDone);
        unique case (state_q)
            StReq: rdreq_subblock = 1'b1;
            StE0: begin
                out_valid   = 1'b1;
                out_data    = h0_q;
                // Counter is still at its load value only during the first triple.
                frame_start = (cnt_q == (len_q ? CntLong : CntShort));
            end
            StE1: begin
                out_valid = 1'b1;
                out_data  = h1_q;
            end
            StE2: begin
                out_valid = 1'b1;
                out_data  = h2_q;
`ifndef SUBBLOCK_PARITY_EN
                frame_end = last_triple;
`endif
            end
`ifdef SUBBLOCK_PARITY_EN
            StPar0: begin
                out_valid = 1'b1;
                out_data  = p0_q;
            end
            StPar1: begin
                out_valid = 1'b1;
                out_data  = p1_q;
            end
            StPar2: begin
                out_valid = 1'b1;
                out_data  = p2_q;
                frame_end = 1'b1;
            end
`endif
            StDone: frame_done = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_subblock_reader.sv
// Self-checking bench for subblock_reader: FIFO model feeding random or fixed byte triples,
// expected stream built from the frame rules (data triples, optional XOR trailer, flags).
module tb_subblock_reader;

    localparam int Short = 132;
    localparam int Long  = 768;
`ifdef SUBBLOCK_PARITY_EN
    localparam int ParBytes = 3;
`else
    localparam int ParBytes = 0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       computation_done;
    logic       length_out;
    logic [7:0] q0, q1, q2;
    logic       rdreq_subblock;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       frame_start;
    logic       frame_end;
    logic       busy;
    logic       frame_done;

    subblock_reader dut (
        .clk              (clk),
        .reset            (reset),
        .computation_done (computation_done),
        .length_out       (length_out),
        .q0               (q0),
        .q1               (q1),
        .q2               (q2),
        .rdreq_subblock   (rdreq_subblock),
        .out_data         (out_data),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .frame_start      (frame_start),
        .frame_end        (frame_end),
        .busy             (busy),
        .frame_done       (frame_done)
    );

    always #5 clk = ~clk;

    // Subblock FIFOs: read data valid one cycle after the strobe.
    logic [7:0] mem0 [8192];
    logic [7:0] mem1 [8192];
    logic [7:0] mem2 [8192];
    int rd_ptr = 0;
    always @(posedge clk) begin
        if (rdreq_subblock) begin
            q0     <= mem0[rd_ptr];
            q1     <= mem1[rd_ptr];
            q2     <= mem2[rd_ptr];
            rd_ptr <= rd_ptr + 1;
        end
    end

    int checks = 0;
    int errors = 0;
    int wr_base = 0;
    int rdreq_n = 0;
    int done_n = 0;
    int cyc = 0;
    int last_done_cyc = 0;
    int gap = -1;
    bit gap_pending = 1'b0;
    bit stall_prev = 1'b0;
    logic [7:0] prev_data = '0;
    logic [7:0] obs_d[$];
    bit obs_s[$];
    bit obs_e[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_rdreq"}, 32'(rdreq_subblock), 0);
        chk({tag, "_data"}, 32'(out_data), 0);
        chk({tag, "_valid"}, 32'(out_valid), 0);
        chk({tag, "_start"}, 32'(frame_start), 0);
        chk({tag, "_end"}, 32'(frame_end), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_done"}, 32'(frame_done), 0);
    endtask

    // One cycle, sampled 1 time unit after the rising edge.
    task automatic step(input logic rdy);
        out_ready = rdy;
        if (stall_prev) begin
            chk("stall_valid", 32'(out_valid), 1);
            chk("stall_data", 32'(out_data), 32'(prev_data));
        end
        if (out_valid && out_ready) begin
            obs_d.push_back(out_data);
            obs_s.push_back(frame_start);
            obs_e.push_back(frame_end);
        end
        if (rdreq_subblock) begin
            rdreq_n++;
            if (gap_pending) begin
                gap = cyc - last_done_cyc;
                gap_pending = 1'b0;
            end
        end
        if (frame_done) begin
            done_n++;
            last_done_cyc = cyc;
            gap_pending = 1'b1;
        end
        stall_prev = out_valid && !out_ready;
        prev_data = out_data;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // kind: 0 random, 1 all A5/3C/FF, 2 as 1 with q0 of triple 7 = 5A.
    // rmode: 0 ready high, 1 ready toggling, 2 ready random.
    task automatic run_frames(input logic len, input int nframes, input int kind, input int rmode);
        int n, flen, obs0, rd0, done0, budget, nobs;
        logic rdy;
        logic [7:0] b0, b1, b2, p0, p1, p2;
        logic [7:0] exp_q[$];
        n = len ? Long : Short;
        flen = 3 * n + ParBytes;
        for (int f = 0; f < nframes; f++) begin
            p0 = '0; p1 = '0; p2 = '0;
            for (int i = 0; i < n; i++) begin
                if (kind == 0) begin
                    b0 = 8'($urandom_range(0, 255));
                    b1 = 8'($urandom_range(0, 255));
                    b2 = 8'($urandom_range(0, 255));
                end else begin
                    b0 = 8'hA5; b1 = 8'h3C; b2 = 8'hFF;
                    if (kind == 2 && i == 7) b0 = 8'h5A;
                end
                mem0[wr_base] = b0; mem1[wr_base] = b1; mem2[wr_base] = b2;
                wr_base++;
                exp_q.push_back(b0); exp_q.push_back(b1); exp_q.push_back(b2);
                p0 ^= b0; p1 ^= b1; p2 ^= b2;
            end
            if (ParBytes != 0) begin
                exp_q.push_back(p0); exp_q.push_back(p1); exp_q.push_back(p2);
            end
        end
        obs0 = obs_d.size();
        rd0 = rdreq_n;
        done0 = done_n;
        gap_pending = 1'b0;
        length_out = len;
        computation_done = 1'b1;
        budget = nframes * flen * 4 + 50;
        while ((done_n - done0) < nframes && budget > 0) begin
            case (rmode)
                0: rdy = 1'b1;
                1: rdy = 1'(cyc & 1);
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            step(rdy);
            if (nframes == 1) computation_done = 1'b0;
            budget--;
        end
        computation_done = 1'b0;
        chk("timeout", 32'(budget > 0), 1);
        nobs = obs_d.size() - obs0;
        chk("byte_count", 32'(nobs), 32'(exp_q.size()));
        for (int k = 0; k < exp_q.size() && k < nobs; k++) begin
            chk("byte", 32'(obs_d[obs0 + k]), 32'(exp_q[k]));
            chk("frame_start", 32'(obs_s[obs0 + k]), 32'((k % flen) == 0));
            chk("frame_end", 32'(obs_e[obs0 + k]), 32'((k % flen) == flen - 1));
        end
        chk("rdreq_count", 32'(rdreq_n - rd0), 32'(nframes * n));
        chk("done_count", 32'(done_n - done0), 32'(nframes));
        chk("fifo_drained", 32'(rd_ptr), 32'(wr_base));
        if (nframes > 1) chk("restart_gap", 32'(gap), 2);
`ifdef SUBBLOCK_PARITY_EN
        if (kind != 0 && nobs >= flen) begin
            chk("trailer0", 32'(obs_d[obs0 + 3 * n]), (kind == 2) ? 32'hFF : 32'h00);
            chk("trailer1", 32'(obs_d[obs0 + 3 * n + 1]), 32'h00);
            chk("trailer2", 32'(obs_d[obs0 + 3 * n + 2]), 32'h00);
        end
`endif
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int obs0, done0, rd_abort, budget;
        reset = 1'b1;
        computation_done = 1'b0;
        length_out = 1'b0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset");
        reset = 1'b0;
        @(posedge clk);
        #1;

        run_frames(1'b0, 1, 0, 0);
        run_frames(1'b1, 1, 0, 0);
        run_frames(1'b1, 1, 0, 1);
        run_frames(1'b0, 1, 0, 2);
        run_frames(1'b0, 1, 1, 0);
        run_frames(1'b0, 1, 2, 1);

        // Abort a long frame after 50 accepted bytes.
        for (int i = 0; i < Long; i++) begin
            mem0[wr_base + i] = 8'($urandom_range(0, 255));
            mem1[wr_base + i] = 8'($urandom_range(0, 255));
            mem2[wr_base + i] = 8'($urandom_range(0, 255));
        end
        obs0 = obs_d.size();
        done0 = done_n;
        length_out = 1'b1;
        computation_done = 1'b1;
        step(1'b1);
        computation_done = 1'b0;
        budget = 2000;
        while ((obs_d.size() - obs0) < 50 && budget > 0) begin
            step(1'b1);
            budget--;
        end
        chk("abort_reach", 32'(budget > 0), 1);
        #1 reset = 1'b1;
        #1 check_zero("abort_async");
        stall_prev = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rd_abort = rdreq_n;
        reset = 1'b0;
        repeat (5) step(1'b1);
        chk("abort_no_done", 32'(done_n), 32'(done0));
        chk("abort_idle", 32'(busy), 0);
        chk("abort_no_rdreq", 32'(rdreq_n), 32'(rd_abort));
        wr_base = rd_ptr;

        run_frames(1'b0, 1, 0, 0);
        run_frames(1'b0, 2, 0, 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
